// File: rtl/music_pkg.sv
// Shared types and helpers for the multi-channel score sequencer.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   // LSB position of channel ch inside a flattened per-channel bus of width w.
   function automatic int unsigned slice_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/tempo_divider.sv
// Programmable step-strobe generator: one step every (tempo + 1) running cycles.
module tempo_divider #(
   parameter int unsigned TEMPO_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic               clear,
   input  logic               load,
   input  logic [TEMPO_W-1:0] tempo_div,
   output logic               step_c
);

   logic [TEMPO_W-1:0] count_q;
   logic [TEMPO_W-1:0] tempo_q;

   assign step_c = run && (count_q == tempo_q);

   // A zero divisor is promoted to 1 so the ROM address is stable for two cycles per step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         tempo_q <= '0;
      end else begin
         if (load)
            tempo_q <= (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
         if (clear)
            count_q <= '0;
         else if (run)
            count_q <= step_c ? '0 : count_q + TEMPO_W'(1);
      end
   end

endmodule

// File: rtl/music_sequencer.sv
// Multi-channel score sequencer: steps per-channel ROM addresses at a tempo and presents notes.
module music_sequencer
   import music_pkg::*;
#(
   parameter int unsigned       NUM_CH    = 2,
   parameter int unsigned       ADDR_W    = 12,
   parameter int unsigned       NOTE_W    = 8,
   parameter int unsigned       TEMPO_W   = 32,
   parameter logic [NOTE_W-1:0] END_CODE  = {NOTE_W{1'b1}},
   parameter logic [NOTE_W-1:0] REST_CODE = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     play,
   input  logic                     pause,
   input  logic                     stop,
   input  logic                     loop_en,
   input  logic [TEMPO_W-1:0]       tempo_div,
   input  logic [NUM_CH-1:0]        mute,
   output logic [NUM_CH*ADDR_W-1:0] rom_addr,
   input  logic [NUM_CH*NOTE_W-1:0] rom_data,
   output logic [NUM_CH*NOTE_W-1:0] note_out,
   output logic                     busy,
   output logic                     song_done,
   output logic [NUM_CH-1:0]        ch_done
);

   seq_state_t        state_q;
   logic [ADDR_W-1:0] addr_q     [NUM_CH];
   logic [ADDR_W-1:0] addr_nxt_c [NUM_CH];
   logic [NOTE_W-1:0] note_q     [NUM_CH];
   logic [NOTE_W-1:0] data_c     [NUM_CH];
   logic [NUM_CH-1:0] ch_done_nxt_c;
   logic              start_c;
   logic              clear_c;
   logic              run_c;
   logic              step_c;

   // run_c is high only for cycles that stay in PLAY; stop and pause both freeze the tick.
   assign start_c = play && !stop && (state_q == ST_IDLE || state_q == ST_DONE);
   assign clear_c = stop || start_c;
   assign run_c   = (state_q == ST_PLAY) && !stop && !(pause && !play);

   tempo_divider #(.TEMPO_W(TEMPO_W)) u_tempo (
      .clock     (clock),
      .reset     (reset),
      .run       (run_c),
      .clear     (clear_c),
      .load      (start_c),
      .tempo_div (tempo_div),
      .step_c    (step_c)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign data_c[c] = rom_data[slice_lsb(c, NOTE_W) +: NOTE_W];
      assign rom_addr[slice_lsb(c, ADDR_W) +: ADDR_W] = addr_q[c];
      assign note_out[slice_lsb(c, NOTE_W) +: NOTE_W] = note_q[c];
   end

   // Per-channel step decision on the data read back for the current address.
   always_comb begin
      ch_done_nxt_c = ch_done;
      for (int c = 0; c < NUM_CH; c++) begin
         addr_nxt_c[c] = addr_q[c];
         if (step_c && !ch_done[c]) begin
            if (data_c[c] == END_CODE) begin
               if (loop_en)
                  addr_nxt_c[c] = '0;
               else
                  ch_done_nxt_c[c] = 1'b1;
            end else begin
               addr_nxt_c[c] = addr_q[c] + ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         busy      <= 1'b0;
         song_done <= 1'b0;
         ch_done   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            addr_q[c] <= '0;
            note_q[c] <= REST_CODE;
         end
      end else begin
         song_done <= 1'b0;
         for (int c = 0; c < NUM_CH; c++)
            note_q[c] <= (run_c && !mute[c] && !ch_done[c] && data_c[c] != END_CODE)
                         ? data_c[c] : REST_CODE;

         if (stop) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            ch_done <= '0;
            for (int c = 0; c < NUM_CH; c++) addr_q[c] <= '0;
         end else if (start_c) begin
            state_q <= ST_PLAY;
            busy    <= 1'b1;
            ch_done <= '0;
            for (int c = 0; c < NUM_CH; c++) addr_q[c] <= '0;
         end else if (play && state_q == ST_PAUSED) begin
            state_q <= ST_PLAY;
         end else if (run_c) begin
            ch_done <= ch_done_nxt_c;
            for (int c = 0; c < NUM_CH; c++) addr_q[c] <= addr_nxt_c[c];
            if (&ch_done_nxt_c) begin
               state_q   <= ST_DONE;
               busy      <= 1'b0;
               song_done <= 1'b1;
            end
         end else if (state_q == ST_PLAY) begin
            // Only way to be in PLAY without running is an honoured pause.
            state_q <= ST_PAUSED;
         end
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a behavioural 1-cycle-latency score ROM.
module tb_music_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        play, pause, stop, loop_en;
   logic [31:0] tempo_div;
   logic [1:0]  mute;
   logic [23:0] rom_addr;
   logic [15:0] rom_data = '0;
   logic [15:0] note_out;
   logic        busy, song_done;
   logic [1:0]  ch_done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          n;
      logic        play, pause, stop, loop_en;
      logic [1:0]  mute;
      logic [31:0] tempo;
      logic [11:0] a0, a1;
      logic [7:0]  n0, n1;
      logic        busy, sd;
      logic [1:0]  cd;
   } vec_t;

   vec_t vecs [27];

   music_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .play      (play),
      .pause     (pause),
      .stop      (stop),
      .loop_en   (loop_en),
      .tempo_div (tempo_div),
      .mute      (mute),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .note_out  (note_out),
      .busy      (busy),
      .song_done (song_done),
      .ch_done   (ch_done)
   );

   always #5 clock = ~clock;

   // Score ROMs: ch0 = {1,2,3,FF,...}, ch1 = {5,FF,...}
   function automatic logic [7:0] rom0(input logic [11:0] a);
      return (a < 12'd3) ? 8'(a + 12'd1) : 8'hFF;
   endfunction
   function automatic logic [7:0] rom1(input logic [11:0] a);
      return (a == 12'd0) ? 8'h05 : 8'hFF;
   endfunction

   always @(posedge clock) rom_data <= {rom1(rom_addr[23:12]), rom0(rom_addr[11:0])};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [11:0] a0, input logic [11:0] a1,
                            input logic [7:0] n0, input logic [7:0] n1,
                            input logic b, input logic sd, input logic [1:0] cd);
      check({tag, " rom_addr"},  32'(rom_addr),  32'({a1, a0}));
      check({tag, " note_out"},  32'(note_out),  32'({n1, n0}));
      check({tag, " busy"},      32'(busy),      32'(b));
      check({tag, " song_done"}, 32'(song_done), 32'(sd));
      check({tag, " ch_done"},   32'(ch_done),   32'(cd));
   endtask

   task automatic apply_row(input int i);
      play      = vecs[i].play;
      pause     = vecs[i].pause;
      stop      = vecs[i].stop;
      loop_en   = vecs[i].loop_en;
      mute      = vecs[i].mute;
      tempo_div = vecs[i].tempo;
      repeat (vecs[i].n) @(posedge clock);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].n0, vecs[i].n1,
                vecs[i].busy, vecs[i].sd, vecs[i].cd);
   endtask

   initial begin
      //             n  ply pse stp lp mute  tempo   a0     a1     n0     n1    bsy sd cd
      // one-shot, tempo 3: steps every 4 cycles, ch1 ends after 2 steps, ch0 after 4
      vecs[0]  = '{1, 1, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[1]  = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[2]  = '{3, 0, 0, 0, 0, 2'b00, 32'd3, 12'd1, 12'd1, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[3]  = '{2, 0, 0, 0, 0, 2'b00, 32'd3, 12'd1, 12'd1, 8'h02, 8'h00, 1, 0, 2'b00};
      vecs[4]  = '{2, 0, 0, 0, 0, 2'b00, 32'd3, 12'd2, 12'd1, 8'h02, 8'h00, 1, 0, 2'b10};
      vecs[5]  = '{4, 0, 0, 0, 0, 2'b00, 32'd3, 12'd3, 12'd1, 8'h03, 8'h00, 1, 0, 2'b10};
      vecs[6]  = '{4, 0, 0, 0, 0, 2'b00, 32'd3, 12'd3, 12'd1, 8'h00, 8'h00, 0, 1, 2'b11};
      vecs[7]  = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd3, 12'd1, 8'h00, 8'h00, 0, 0, 2'b11};
      vecs[8]  = '{5, 0, 0, 0, 0, 2'b00, 32'd3, 12'd3, 12'd1, 8'h00, 8'h00, 0, 0, 2'b11};
      // restart from DONE in loop mode
      vecs[9]  = '{1, 1, 0, 0, 1, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      // stop and play together while playing: stop wins
      vecs[10] = '{1, 1, 0, 1, 1, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 0, 0, 2'b00};
      vecs[11] = '{2, 0, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 0, 0, 2'b00};
      // pause with tick count 2, hold 20 cycles, resume: step lands 2 cycles after resume
      vecs[12] = '{1, 1, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[13] = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[14] = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[15] = '{1, 0, 1, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[16] = '{19, 0, 1, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[17] = '{1, 1, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[18] = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[19] = '{1, 0, 0, 0, 0, 2'b00, 32'd3, 12'd1, 12'd1, 8'h01, 8'h05, 1, 0, 2'b00};
      // mute ch0: silenced next cycle, ch1 unaffected, ch0 address keeps stepping
      vecs[20] = '{1, 0, 0, 0, 0, 2'b01, 32'd3, 12'd1, 12'd1, 8'h00, 8'h05, 1, 0, 2'b00};
      vecs[21] = '{3, 0, 0, 0, 0, 2'b01, 32'd3, 12'd2, 12'd1, 8'h00, 8'h00, 1, 0, 2'b10};
      vecs[22] = '{2, 0, 0, 0, 0, 2'b00, 32'd3, 12'd2, 12'd1, 8'h03, 8'h00, 1, 0, 2'b10};
      // tempo_div 0 behaves as 1: step period 2
      vecs[23] = '{1, 0, 0, 1, 0, 2'b00, 32'd3, 12'd0, 12'd0, 8'h00, 8'h00, 0, 0, 2'b00};
      vecs[24] = '{1, 1, 0, 0, 0, 2'b00, 32'd0, 12'd0, 12'd0, 8'h00, 8'h00, 1, 0, 2'b00};
      vecs[25] = '{2, 0, 0, 0, 0, 2'b00, 32'd0, 12'd1, 12'd1, 8'h01, 8'h05, 1, 0, 2'b00};
      vecs[26] = '{2, 0, 0, 0, 0, 2'b00, 32'd0, 12'd2, 12'd1, 8'h02, 8'h00, 1, 0, 2'b10};

      reset = 1'b1; play = 0; pause = 0; stop = 0; loop_en = 0; mute = '0; tempo_div = 32'd3;
      #12;
      check_all("reset", 12'd0, 12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i <= 9; i++) apply_row(i);

      // 40 looping steps: ch0 walks 0..3, ch1 0..1, song never completes
      play = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         repeat (4) @(posedge clock);
         #1;
         check($sformatf("loop%0d addr0", k), 32'(rom_addr[11:0]),  32'(k % 4));
         check($sformatf("loop%0d addr1", k), 32'(rom_addr[23:12]), 32'(k % 2));
         check($sformatf("loop%0d song_done", k), 32'(song_done), 32'd0);
      end
      check("loop busy", 32'(busy), 32'd1);

      for (int i = 10; i <= 26; i++) apply_row(i);

      // asynchronous reset mid-song, then idle with no leftover pulse
      reset = 1'b1;
      #2;
      check_all("async_reset", 12'd0, 12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_all("post_reset", 12'd0, 12'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
